io_input_device: RTL

- Peripheral-side source for the processor's 8-bit input port; the other end of the in_dev_hs / in_dev_ack handshake.
- A host side (bench, keypad model or UART front end) pushes bytes into an internal FIFO.
- The block presents the bytes one at a time on input_bus with a four-phase handshake: hs up, ack up, hs down, ack down.
- in_dev_hs also drives the processor's interrupt source 3, so hs is held as a clean level for the whole transfer.

---
 rtl/io_input_device.sv | 136 +++++++++++++
 1 files changed

// File: rtl/io_input_device.sv
// Peripheral-side byte source for the processor input port: host FIFO plus a
// four-phase hs/ack presenter. Optional ack watchdog under IODEV_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a queued byte with ack low
// SETUP   | byte on input_bus, hs still low for one cycle of data setup
// PRESENT | hs high, waiting for ack
// RELEASE | hs low, waiting for ack to fall
module io_input_device #(
   parameter int DEPTH       = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                   g_clk,
   input  logic                   g_clr,
   input  logic                   host_wr,
   input  logic [7:0]             host_data,
   output logic                   host_full,
   output logic [$clog2(DEPTH):0] host_count,
   input  logic                   in_dev_ack,
   output logic [7:0]             input_bus,
   output logic                   in_dev_hs,
   output logic                   busy,
   output logic                   xfer_done,
   output logic                   timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, SETUP, PRESENT, RELEASE} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Full is judged on the pre-pop count, so a push into a full FIFO is dropped
   // even on the cycle the head is popped.
   assign host_full = (host_count == CW'(DEPTH));
   assign push      = host_wr && !host_full;
   assign pop       = (state == IDLE) && (host_count != '0) && !in_dev_ack;
   assign busy      = (state != IDLE);

   always_ff @(posedge g_clk) begin
      if (push) begin
         mem[wr_ptr] <= host_data;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         host_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   host_count <= host_count + CW'(1);
            2'b01:   host_count <= host_count - CW'(1);
            default: host_count <= host_count;
         endcase
      end
   end

`ifdef IODEV_TIMEOUT_EN
   localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

   logic [TW-1:0] tmo_cnt;
`else
   logic unused_ack_timeout;

   assign unused_ack_timeout = (ACK_TIMEOUT > 0);
   assign timeout_err        = 1'b0;
`endif

   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         state     <= IDLE;
         input_bus <= 8'h00;
         in_dev_hs <= 1'b0;
         xfer_done <= 1'b0;
`ifdef IODEV_TIMEOUT_EN
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         xfer_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  input_bus <= mem[rd_ptr];
                  state     <= SETUP;
               end
            end
            SETUP: begin
               in_dev_hs <= 1'b1;
               state     <= PRESENT;
`ifdef IODEV_TIMEOUT_EN
               tmo_cnt   <= '0;
`endif
            end
            PRESENT: begin
               // Ack takes priority over a watchdog expiry on the same cycle.
               if (in_dev_ack) begin
                  in_dev_hs <= 1'b0;
                  xfer_done <= 1'b1;
                  state     <= RELEASE;
               end
`ifdef IODEV_TIMEOUT_EN
               else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                  in_dev_hs   <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= RELEASE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
`endif
            end
            RELEASE: begin
               if (!in_dev_ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
